delay_scheduler: RTL and testbench

Event scheduler for the transceiver's timing path. It accepts tagged delay requests through a valid/ready handshake and queues them in a small FIFO. It then runs them one at a time through a down-counter, emitting a one-cycle tagged event when each programmed delay expires. It sits between the frame control logic and the fixed-delay primitives, so that variable, run-time delays are sequenced by one counter instead of many shift-register instances.

---
 rtl/delay_scheduler.sv | 131 +++++++++++++
 tb/tb_delay_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scheduler.sv
// delay_scheduler: queues tagged delay requests in a small FIFO and runs them
// one at a time through a single down-counter, pulsing evt_valid with the tag
// when each delay expires.
// Optional feature macro: DELAY_SCHED_CANCEL_EN (adds the flush input).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no active request; pops the FIFO head as soon as one is queued
// COUNT | active request counting down; expires when cnt reaches zero
module delay_scheduler #(
    parameter int CNT_W = 8,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [CNT_W-1:0]             req_delay,
    input  logic [TAG_W-1:0]             req_tag,
`ifdef DELAY_SCHED_CANCEL_EN
    input  logic                         flush,
`endif
    output logic                         evt_valid,
    output logic [TAG_W-1:0]             evt_tag,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W+TAG_W-1:0]   mem [DEPTH];
    logic [AW:0]              wptr, rptr;
    logic [CNT_W-1:0]         cnt;
    logic [TAG_W-1:0]         tag_act;
    logic                     empty, full, push, pop, expire, flush_i;
    logic [CNT_W-1:0]         head_delay;
    logic [TAG_W-1:0]         head_tag;

`ifdef DELAY_SCHED_CANCEL_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign req_ready = !full && !flush_i;
    assign push      = req_valid && req_ready;
    assign pending   = wptr - rptr;
    assign busy      = (state == COUNT);
    assign {head_delay, head_tag} = mem[rptr[AW-1:0]];

    // Next-state and pop decision; flush overrides everything, including an expiry.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (cnt == '0) begin
                    expire = 1'b1;
                    if (!empty) pop = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            pop       = 1'b0;
            expire    = 1'b0;
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FIFO storage; entries are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {req_delay, req_tag};
    end

    // FIFO pointers; a flush discards everything queued (no push can coincide).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            rptr <= wptr;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Down-counter, active tag latch and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tag_act   <= '0;
            evt_valid <= 1'b0;
            evt_tag   <= '0;
        end else if (flush_i) begin
            cnt       <= '0;
            evt_valid <= 1'b0;
        end else begin
            evt_valid <= expire;
            if (expire) evt_tag <= tag_act;
            if (pop) begin
                cnt     <= head_delay;
                tag_act <= head_tag;
            end else if (state == COUNT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Testbench for delay_scheduler: directed scenarios plus randomized traffic,
// all checked against a timestamp model (each request's pop and fire edge are
// computed arithmetically from its accept edge and the previous fire edge).
module tb_delay_scheduler;

    localparam int CNT_W = 8;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [CNT_W-1:0]  req_delay = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              flush_s = 1'b0;
    logic              evt_valid;
    logic [TAG_W-1:0]  evt_tag;
    logic              busy;
    logic [PW-1:0]     pending;

    int checks = 0;
    int errors = 0;

    // Model state: one entry per accepted request.
    int               acc_q[$];
    int               pop_q[$];
    int               fire_q[$];
    logic [TAG_W-1:0] tag_q[$];
    int               last_fire;
    logic [TAG_W-1:0] last_tag;
    int               t;
    logic [TAG_W-1:0] fired_log[$];

    delay_scheduler #(.CNT_W(CNT_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_delay (req_delay),
        .req_tag   (req_tag),
`ifdef DELAY_SCHED_CANCEL_EN
        .flush     (flush_s),
`endif
        .evt_valid (evt_valid),
        .evt_tag   (evt_tag),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        acc_q.delete(); pop_q.delete(); fire_q.delete(); tag_q.delete();
        last_fire = -100;
        last_tag  = '0;
        t         = -1;
    endfunction

    function automatic void model_accept(int a, int d, logic [TAG_W-1:0] tg);
        acc_q.push_back(a);
        tag_q.push_back(tg);
        if (a < last_fire) begin
            pop_q.push_back(last_fire);
            fire_q.push_back(last_fire + d + 1);
        end else begin
            pop_q.push_back(a + 1);
            fire_q.push_back(a + d + 2);
        end
        last_fire = fire_q[$];
    endfunction

    function automatic void model_flush(int e);
        for (int i = fire_q.size() - 1; i >= 0; i--) begin
            if (fire_q[i] >= e) begin
                acc_q.delete(i); pop_q.delete(i); fire_q.delete(i); tag_q.delete(i);
            end
        end
        last_fire = -100;
    endfunction

    function automatic int model_pending(int e);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] <= e && pop_q[i] > e) n++;
        return n;
    endfunction

    function automatic bit model_busy(int e);
        foreach (pop_q[i]) if (pop_q[i] <= e && e < fire_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_max_fire();
        int m = -1;
        foreach (fire_q[i]) if (fire_q[i] > m) m = fire_q[i];
        return m;
    endfunction

    task automatic do_reset();
        req_valid = 1'b0; req_delay = '0; req_tag = '0; flush_s = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        fired_log.delete();
    endtask

    // One clock of stimulus with full comparison of every output against the model.
    task automatic step(input logic v, input int d, input logic [TAG_W-1:0] tg,
                        input logic fl, output bit accepted);
        logic exp_rdy;
        bit   exp_ev;
        logic [TAG_W-1:0] exp_tag;
        int   exp_pend;
        req_valid = v; req_delay = CNT_W'(d); req_tag = tg; flush_s = fl;
        #1;
        exp_rdy = (model_pending(t) < DEPTH) && !fl;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0d got %b exp %b", t, req_ready, exp_rdy);
        end
        @(posedge clk);
        t++;
        if (fl) model_flush(t);
        accepted = v && exp_rdy;
        if (accepted) model_accept(t, d, tg);
        #1;
        exp_ev = 1'b0;
        foreach (fire_q[i]) if (fire_q[i] == t) begin exp_ev = 1'b1; last_tag = tag_q[i]; end
        exp_tag  = last_tag;
        exp_pend = model_pending(t);
        checks++;
        if (evt_valid !== exp_ev) begin
            errors++;
            $display("FAIL evt_valid t=%0d got %b exp %b", t, evt_valid, exp_ev);
        end
        checks++;
        if (evt_tag !== exp_tag) begin
            errors++;
            $display("FAIL evt_tag t=%0d got %0d exp %0d", t, evt_tag, exp_tag);
        end
        checks++;
        if (busy !== model_busy(t)) begin
            errors++;
            $display("FAIL busy t=%0d got %b exp %b", t, busy, model_busy(t));
        end
        checks++;
        if (pending !== PW'(exp_pend)) begin
            errors++;
            $display("FAIL pending t=%0d got %0d exp %0d", t, pending, exp_pend);
        end
        if (evt_valid === 1'b1) fired_log.push_back(evt_tag);
        req_valid = 1'b0; flush_s = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b0, a);
    endtask

    task automatic drain();
        int guard = 0;
        while (t < model_max_fire() && guard < 3000) begin
            idle(1);
            guard++;
        end
        checks++;
        if (t < model_max_fire()) begin
            errors++;
            $display("FAIL drain_timeout t=%0d exp_last_fire %0d", t, model_max_fire());
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b0; flush_s = 1'b0;
        rst_n = 1'b0;
        #7;
        checks++;
        if ({evt_valid, evt_tag, busy, pending, req_ready} !== {1'b0, {TAG_W{1'b0}}, 1'b0, {PW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got ev=%b tag=%0d busy=%b pend=%0d rdy=%b exp 0 0 0 0 1",
                     evt_valid, evt_tag, busy, pending, req_ready);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit a;
        int pulses = 0, pulse_t = -1, busy_cnt = 0;
        do_reset();
        step(1'b1, 5, 4'd3, 1'b0, a);
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (busy === 1'b1) busy_cnt++;
            if (evt_valid === 1'b1) begin pulses++; pulse_t = t; end
        end
        checks++;
        if (pulses != 1 || pulse_t != 7) begin
            errors++;
            $display("FAIL single_pulse got %0d pulses at edge %0d exp 1 at edge 7", pulses, pulse_t);
        end
        checks++;
        if (busy_cnt != 6) begin
            errors++;
            $display("FAIL single_busy got %0d cycles exp 6", busy_cnt);
        end
    endtask

    task automatic test_zero_delay();
        bit a;
        int pulses = 0, pulse_t = -1;
        do_reset();
        step(1'b1, 0, 4'd1, 1'b0, a);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (evt_valid === 1'b1) begin pulses++; pulse_t = t; end
        end
        checks++;
        if (pulses != 1 || pulse_t != 2 || evt_tag !== 4'd1) begin
            errors++;
            $display("FAIL zero_delay got %0d pulses at edge %0d tag %0d exp 1 at edge 2 tag 1",
                     pulses, pulse_t, evt_tag);
        end
    endtask

    task automatic test_fill();
        bit a;
        int tries;
        do_reset();
        step(1'b1, 10, 4'd0, 1'b0, a);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                checks++;
                if (pending !== PW'(4) || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_full got pend=%0d rdy=%b exp pend=4 rdy=0", pending, req_ready);
                end
            end
            tries = 0;
            a = 1'b0;
            while (!a && tries < 40) begin
                step(1'b1, 1, TAG_W'(k), 1'b0, a);
                tries++;
            end
            checks++;
            if (!a) begin
                errors++;
                $display("FAIL fill_accept tag %0d not accepted within 40 cycles", k);
            end
        end
        drain();
        checks++;
        if (fired_log.size() != 6) begin
            errors++;
            $display("FAIL fill_count got %0d events exp 6", fired_log.size());
        end
        foreach (fired_log[i]) begin
            checks++;
            if (fired_log[i] !== TAG_W'(i)) begin
                errors++;
                $display("FAIL fill_order idx %0d got tag %0d exp %0d", i, fired_log[i], i);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit a;
        int ev_t[$];
        int ev_p[$];
        do_reset();
        step(1'b1, 9, 4'd1, 1'b0, a);
        step(1'b1, 3, 4'd2, 1'b0, a);
        step(1'b1, 2, 4'd3, 1'b0, a);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (evt_valid === 1'b1) begin ev_t.push_back(t); ev_p.push_back(int'(pending)); end
        end
        checks++;
        if (ev_t.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d events exp 3", ev_t.size());
        end else begin
            checks++;
            if (ev_t[0] != 11 || ev_t[1] - ev_t[0] != 4 || ev_t[2] - ev_t[1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing got edges %0d %0d %0d exp 11 15 18", ev_t[0], ev_t[1], ev_t[2]);
            end
            checks++;
            if (ev_p[0] != 1 || ev_p[1] != 0) begin
                errors++;
                $display("FAIL b2b_pending got %0d %0d exp 1 0", ev_p[0], ev_p[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        int pulses = 0;
        do_reset();
        step(1'b1, 0, 4'd9, 1'b0, a);
        step(1'b1, 20, 4'd1, 1'b0, a);
        step(1'b1, 20, 4'd2, 1'b0, a);
        step(1'b1, 20, 4'd3, 1'b0, a);
        idle(3);
        checks++;
        if (pending !== PW'(2) || busy !== 1'b1 || evt_tag !== 4'd9) begin
            errors++;
            $display("FAIL rstmid_pre got pend=%0d busy=%b tag=%0d exp 2 1 9", pending, busy, evt_tag);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_tag, busy, pending, req_ready} !== {1'b0, {TAG_W{1'b0}}, 1'b0, {PW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_clear got ev=%b tag=%0d busy=%b pend=%0d rdy=%b exp 0 0 0 0 1",
                     evt_valid, evt_tag, busy, pending, req_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (evt_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstmid_no_event got %0d events exp 0", pulses);
        end
    endtask

`ifdef DELAY_SCHED_CANCEL_EN
    task automatic test_flush();
        bit a;
        int pulse_t = -1, pulses = 0;
        do_reset();
        step(1'b1, 3, 4'd5, 1'b0, a);
        step(1'b1, 4, 4'd6, 1'b0, a);
        idle(3);
        step(1'b1, 2, 4'd7, 1'b1, a);
        checks++;
        if (a || evt_valid !== 1'b0 || pending !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_expiry got acc=%b ev=%b pend=%0d busy=%b exp 0 0 0 0",
                     a, evt_valid, pending, busy);
        end
        step(1'b1, 1, 4'd8, 1'b0, a);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (evt_valid === 1'b1) begin pulses++; pulse_t = t; end
        end
        checks++;
        if (pulses != 1 || pulse_t != 9 || evt_tag !== 4'd8) begin
            errors++;
            $display("FAIL flush_after got %0d pulses at edge %0d tag %0d exp 1 at edge 9 tag 8",
                     pulses, pulse_t, evt_tag);
        end
    endtask
`endif

    task automatic test_random(input int n, input int load_pct, input int dmax);
        bit a;
        logic v, fl;
        do_reset();
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 99) < load_pct);
            fl = 1'b0;
`ifdef DELAY_SCHED_CANCEL_EN
            fl = ($urandom_range(0, 39) == 0);
`endif
            step(v, (($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, dmax))),
                 TAG_W'($urandom), fl, a);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_delay();
        test_fill();
        test_back_to_back();
        test_reset_mid();
`ifdef DELAY_SCHED_CANCEL_EN
        test_flush();
`endif
        test_random(400, 80, 6);
        test_random(400, 15, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
